// File: rtl/param_rob_pkg.sv
// Shared reorder-buffer types and pointer helpers.
// Pointers are {position bit, index}; distances wrap at 2**pw.
package param_rob_pkg;

   typedef struct packed {
      logic occ;
      logic cpl;
      logic excp;
      logic redir;
      logic serial;
   } rob_flags_t;

   function automatic logic [31:0] ptr_dist(
      input logic [31:0] a,
      input logic [31:0] b,
      input int          pw
   );
      logic [31:0] m;
      m = (32'd1 << pw) - 32'd1;
      return (a - b) & m;
   endfunction

   function automatic logic ptr_in_range(
      input logic [31:0] p,
      input logic [31:0] h,
      input logic [31:0] t,
      input int          pw
   );
      return ptr_dist(p, h, pw) < ptr_dist(t, h, pw);
   endfunction

endpackage

// File: rtl/param_rob_commit_sel.sv
// In-order commit lane chain: a lane commits only behind a committed lane
// that neither stops the group nor is serial.
module rob_commit_sel #(
   parameter int CMT_W = 2
) (
   input  logic             en,
   input  logic [CMT_W-1:0] rdy,
   input  logic [CMT_W-1:0] stop,
   input  logic [CMT_W-1:0] serial,
   output logic [CMT_W-1:0] valid
);

   always_comb begin
      logic go;
      valid = '0;
      go    = en;
      for (int i = 0; i < CMT_W; i++) begin
         valid[i] = go & rdy[i] & ((i == 0) | ~serial[i]);
         go       = valid[i] & ~stop[i] & ~serial[i];
      end
   end

endmodule

// File: rtl/param_rob.sv
// Parameterised reorder buffer: multi-lane allocate, out-of-order writeback,
// in-order multi-lane commit, squash to a surviving pointer and full flush.
module param_rob
   import param_rob_pkg::*;
#(
   parameter int DEPTH     = 32,
   parameter int ALLOC_W   = 2,
   parameter int CMT_W     = 2,
   parameter int WB_N      = 4,
   parameter int PAYLOAD_W = 64,
   localparam int PW       = $clog2(DEPTH) + 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush_i,
   input  logic [ALLOC_W-1:0]         alloc_valid_i,
   input  logic [ALLOC_W*PAYLOAD_W-1:0] alloc_payload_i,
   input  logic [ALLOC_W-1:0]         alloc_excp_i,
   input  logic [ALLOC_W-1:0]         alloc_serial_i,
   output logic                       alloc_ready_o,
   output logic [ALLOC_W*PW-1:0]      alloc_ptr_o,
   input  logic [WB_N-1:0]            wb_valid_i,
   input  logic [WB_N*PW-1:0]         wb_ptr_i,
   input  logic [WB_N-1:0]            wb_excp_i,
   input  logic [WB_N-1:0]            wb_redirect_i,
   input  logic                       squash_valid_i,
   input  logic [PW-1:0]              squash_ptr_i,
   output logic [CMT_W-1:0]           cmt_valid_o,
   output logic [CMT_W*PAYLOAD_W-1:0] cmt_payload_o,
   output logic [CMT_W-1:0]           cmt_excp_o,
   output logic [CMT_W-1:0]           cmt_redirect_o,
   output logic [PW-1:0]              head_ptr_o,
   output logic [PW-1:0]              count_o,
   output logic                       empty_o
);

   localparam int IW = PW - 1;

   logic [PW-1:0]        head, tail, count;
   logic [PW-1:0]        n_alloc, n_cmt, sq_tail;
   logic [PW-1:0]        aptr [ALLOC_W];
   logic [IW-1:0]        c_idx [CMT_W];
   logic [CMT_W-1:0]     c_rdy, c_stop, c_ser, c_val;
   logic [DEPTH-1:0]     sq_kill;
   rob_flags_t           flags [DEPTH];
   logic [PAYLOAD_W-1:0] payload [DEPTH];

   assign count      = tail - head;
   assign count_o    = count;
   assign head_ptr_o = head;
   assign empty_o    = (count == '0);
   assign sq_tail    = squash_ptr_i + PW'(1);

   assign alloc_ready_o = (int'(DEPTH) - int'(count) >= int'(ALLOC_W))
                          & ~squash_valid_i & ~flush_i;

   // Valid lanes are packed onto consecutive tail slots.
   always_comb begin
      n_alloc = '0;
      for (int k = 0; k < ALLOC_W; k++) begin
         aptr[k] = tail + n_alloc;
         alloc_ptr_o[k*PW +: PW] = aptr[k];
         n_alloc = n_alloc + PW'(alloc_valid_i[k]);
      end
   end

   always_comb begin
      for (int i = 0; i < CMT_W; i++) begin
         c_idx[i]  = head[IW-1:0] + IW'(i);
         c_rdy[i]  = flags[c_idx[i]].occ & flags[c_idx[i]].cpl;
         c_stop[i] = flags[c_idx[i]].excp | flags[c_idx[i]].redir;
         c_ser[i]  = flags[c_idx[i]].serial;
      end
   end

   rob_commit_sel #(
      .CMT_W (CMT_W)
   ) u_sel (
      .en     (~flush_i),
      .rdy    (c_rdy),
      .stop   (c_stop),
      .serial (c_ser),
      .valid  (c_val)
   );

   always_comb begin
      n_cmt = '0;
      for (int i = 0; i < CMT_W; i++) begin
         cmt_payload_o[i*PAYLOAD_W +: PAYLOAD_W] = payload[c_idx[i]];
         cmt_excp_o[i]     = flags[c_idx[i]].excp;
         cmt_redirect_o[i] = flags[c_idx[i]].redir;
         n_cmt = n_cmt + PW'(c_val[i]);
      end
   end

   assign cmt_valid_o = c_val;

   // Entries at or beyond the surviving tail lose occupancy on squash.
   always_comb begin
      for (int i = 0; i < DEPTH; i++)
         sq_kill[i] = ptr_dist(32'(i), 32'(head), IW)
                      >= ptr_dist(32'(sq_tail), 32'(head), PW);
   end

   always_ff @(posedge clk) begin
      if (!rst_n || flush_i) begin
         head <= '0;
         tail <= '0;
         for (int i = 0; i < DEPTH; i++)
            flags[i] <= '0;
      end else begin
         for (int p = 0; p < WB_N; p++) begin
            if (wb_valid_i[p] &&
                ptr_in_range(32'(wb_ptr_i[p*PW +: PW]),
                             32'(head), 32'(tail), PW)) begin
               flags[wb_ptr_i[p*PW +: IW]].cpl   <= 1'b1;
               flags[wb_ptr_i[p*PW +: IW]].excp  <=
                  flags[wb_ptr_i[p*PW +: IW]].excp | wb_excp_i[p];
               flags[wb_ptr_i[p*PW +: IW]].redir <= wb_redirect_i[p];
            end
         end
         for (int i = 0; i < CMT_W; i++)
            if (c_val[i])
               flags[c_idx[i]].occ <= 1'b0;
         if (alloc_ready_o) begin
            for (int k = 0; k < ALLOC_W; k++)
               if (alloc_valid_i[k])
                  flags[aptr[k][IW-1:0]] <= '{occ:    1'b1,
                                              cpl:    alloc_excp_i[k],
                                              excp:   alloc_excp_i[k],
                                              redir:  1'b0,
                                              serial: alloc_serial_i[k]};
         end
         if (squash_valid_i) begin
            for (int i = 0; i < DEPTH; i++)
               if (sq_kill[i])
                  flags[i].occ <= 1'b0;
         end
         head <= head + n_cmt;
         if (squash_valid_i)
            tail <= sq_tail;
         else if (alloc_ready_o)
            tail <= tail + n_alloc;
      end
   end

   always_ff @(posedge clk) begin
      if (alloc_ready_o) begin
         for (int k = 0; k < ALLOC_W; k++)
            if (alloc_valid_i[k])
               payload[aptr[k][IW-1:0]] <=
                  alloc_payload_i[k*PAYLOAD_W +: PAYLOAD_W];
      end
   end

endmodule
